// File: rtl/fifo_flow_pkg.sv
// Shared types, default constants and the packed-level slice helper
// for the FIFO flow manager.
package fifo_flow_pkg;

    typedef enum logic [0:0] {
        FF_RUN   = 1'b0,
        FF_STALL = 1'b1
    } ff_state_t;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_THRESH = DEF_DEPTH - 2;
    localparam int DEF_AE_THRESH = 1;
    localparam int DEF_HYST      = 2;

    // Widest level count and packed bus the slice helper can address.
    localparam int MAX_CNT_W = 16;
    localparam int LVL_BUS_W = 128;

    // Extract channel idx from a packed level bus with cnt_w bits per channel.
    function automatic logic [MAX_CNT_W-1:0] level_slice(
        input logic [LVL_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          cnt_w
    );
        logic [MAX_CNT_W-1:0] mask_v;
        mask_v = ~({MAX_CNT_W{1'b1}} << cnt_w);
        return MAX_CNT_W'(bus >> (idx * cnt_w)) & mask_v;
    endfunction

endpackage

// File: rtl/fifo_ch_err.sv
// Per-channel overflow/underflow detection with sticky error flags.
// Set has priority over clear so no error event is lost.
module fifo_ch_err
    import fifo_flow_pkg::*;
#(
    parameter int CNT_W = 5,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [CNT_W-1:0] level,
    input  logic             err_clr,
    output logic             ovf_next,
    output logic             udf_next,
    output logic             ovf_err,
    output logic             udf_err
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

    logic ovf_set_s;
    logic udf_set_s;
    logic ovf_r;
    logic udf_r;

    // Push without a matching pop at exactly full overflows; any pop at empty underflows.
    always_comb begin
        ovf_set_s = en & push & ~pop & (level == DEPTH_C);
        udf_set_s = en & pop & (level == ZERO_C);
        ovf_next  = ovf_set_s | (ovf_r & ~err_clr);
        udf_next  = udf_set_s | (udf_r & ~err_clr);
    end

    // Sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_next;
            udf_r <= udf_next;
        end
    end

    assign ovf_err = ovf_r;
    assign udf_err = udf_r;

endmodule

// File: rtl/fifo_flow_manager.sv
// Registered FIFO ready-flag generator: full path with hysteresis,
// almost-empty path, channel masking and sticky error interrupt.
module fifo_flow_manager
    import fifo_flow_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = $clog2(DEPTH + 1),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int HYST      = DEF_HYST,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*CNT_W-1:0] level,
    input  logic [NUM_CH-1:0]       push,
    input  logic [NUM_CH-1:0]       pop,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    err_clr,
    output logic                    fready_full,
    output logic                    fready_empty,
    output logic [NUM_CH-1:0]       ovf_err,
    output logic [NUM_CH-1:0]       udf_err,
    output logic                    irq
);

    localparam logic [CNT_W-1:0] AF_C  = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] REL_C = CNT_W'(AF_THRESH - 1 - HYST);
    localparam logic [CNT_W-1:0] AE_C  = CNT_W'(AE_THRESH);

    logic [LVL_BUS_W-1:0] level_bus_s;
    logic [CNT_W-1:0]     ch_level_s [NUM_CH];
    logic [NUM_CH-1:0]    ovf_next_s;
    logic [NUM_CH-1:0]    udf_next_s;
    logic                 af_any_s;
    logic                 rel_all_s;
    logic                 ae_all_s;
    logic                 fe_next_s;
    ff_state_t            state_r;
    ff_state_t            state_next_s;
    logic                 fready_full_r;
    logic                 fready_empty_r;
    logic                 irq_r;

    assign level_bus_s = LVL_BUS_W'(level);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_level_s[gi] = CNT_W'(level_slice(level_bus_s, gi, CNT_W));

            fifo_ch_err #(
                .CNT_W (CNT_W),
                .DEPTH (DEPTH)
            ) u_err (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (ch_en[gi]),
                .push     (push[gi]),
                .pop      (pop[gi]),
                .level    (ch_level_s[gi]),
                .err_clr  (err_clr),
                .ovf_next (ovf_next_s[gi]),
                .udf_next (udf_next_s[gi]),
                .ovf_err  (ovf_err[gi]),
                .udf_err  (udf_err[gi])
            );
        end
    endgenerate

    // Reduce per-channel threshold compares over the enabled channels only.
    always_comb begin
        af_any_s  = 1'b0;
        rel_all_s = 1'b1;
        ae_all_s  = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            af_any_s  = af_any_s  | (ch_en[i] & (ch_level_s[i] >= AF_C));
            rel_all_s = rel_all_s & (~ch_en[i] | (ch_level_s[i] <= REL_C));
            ae_all_s  = ae_all_s  & (~ch_en[i] | (ch_level_s[i] >= AE_C));
        end
        fe_next_s = (|ch_en) & ae_all_s;
    end

    // Full-path next state: stall on almost-full, release only below the hysteresis band.
    always_comb begin
        state_next_s = state_r;
        if (ch_en == '0) begin
            state_next_s = FF_RUN;
        end else begin
            case (state_r)
                FF_RUN: begin
                    if (af_any_s) state_next_s = FF_STALL;
                    else          state_next_s = FF_RUN;
                end
                FF_STALL: begin
                    if (rel_all_s) state_next_s = FF_RUN;
                    else           state_next_s = FF_STALL;
                end
                default: state_next_s = FF_RUN;
            endcase
        end
    end

    // State and output registers; ready flags and irq follow the next-state values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= FF_RUN;
            fready_full_r  <= 1'b1;
            fready_empty_r <= 1'b0;
            irq_r          <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            fready_full_r  <= (state_next_s == FF_RUN);
            fready_empty_r <= fe_next_s;
            irq_r          <= |(ovf_next_s | udf_next_s);
        end
    end

    assign fready_full  = fready_full_r;
    assign fready_empty = fready_empty_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_fifo_flow_manager.sv
// Directed scoreboard bench for fifo_flow_manager (NUM_CH=2, DEPTH=16).
module tb_fifo_flow_manager;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 5;

    typedef struct {
        string      tag;
        logic       ff;
        logic       fe;
        logic [1:0] ovf;
        logic [1:0] udf;
        logic       irq;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*CNT_W-1:0] level;
    logic [NUM_CH-1:0]       push;
    logic [NUM_CH-1:0]       pop;
    logic [NUM_CH-1:0]       ch_en;
    logic                    err_clr;
    logic                    fready_full;
    logic                    fready_empty;
    logic [NUM_CH-1:0]       ovf_err;
    logic [NUM_CH-1:0]       udf_err;
    logic                    irq;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    fifo_flow_manager #(.NUM_CH(NUM_CH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .level        (level),
        .push         (push),
        .pop          (pop),
        .ch_en        (ch_en),
        .err_clr      (err_clr),
        .fready_full  (fready_full),
        .fready_empty (fready_empty),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rst_v, input int l0, input int l1,
                         input logic [1:0] psh, input logic [1:0] pp,
                         input logic [1:0] en, input logic clr);
        rst_n   = rst_v;
        level   = {CNT_W'(l1), CNT_W'(l0)};
        push    = psh;
        pop     = pp;
        ch_en   = en;
        err_clr = clr;
    endtask

    // Queue the expectation for this edge, clock once, then pop and compare mid-cycle.
    task automatic step(input string tag, input logic ff, input logic fe,
                        input logic [1:0] ovf, input logic [1:0] udf, input logic iq);
        exp_t e;
        e.tag = tag; e.ff = ff; e.fe = fe; e.ovf = ovf; e.udf = udf; e.irq = iq;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        assert (fready_full === e.ff) else begin
            errors++; $error("FAIL %s fready_full got %b exp %b", e.tag, fready_full, e.ff);
        end
        checks++;
        assert (fready_empty === e.fe) else begin
            errors++; $error("FAIL %s fready_empty got %b exp %b", e.tag, fready_empty, e.fe);
        end
        checks++;
        assert (ovf_err === e.ovf) else begin
            errors++; $error("FAIL %s ovf_err got %b exp %b", e.tag, ovf_err, e.ovf);
        end
        checks++;
        assert (udf_err === e.udf) else begin
            errors++; $error("FAIL %s udf_err got %b exp %b", e.tag, udf_err, e.udf);
        end
        checks++;
        assert (irq === e.irq) else begin
            errors++; $error("FAIL %s irq got %b exp %b", e.tag, irq, e.irq);
        end
    endtask

    initial begin
        // Reset and idle
        drive(1'b0, 0, 0, 2'b00, 2'b00, 2'b11, 1'b0);
        step("reset",        1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 0, 0, 2'b00, 2'b00, 2'b11, 1'b0);
        step("idle",         1'b1, 1'b0, 2'b00, 2'b00, 1'b0);

        // Hysteresis on the full path
        drive(1'b1, 13, 5, 2'b00, 2'b00, 2'b11, 1'b0);
        step("af_below",     1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 14, 5, 2'b00, 2'b00, 2'b11, 1'b0);
        step("af_hit",       1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 12, 5, 2'b00, 2'b00, 2'b11, 1'b0);
        step("hyst_hold",    1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 11, 5, 2'b00, 2'b00, 2'b11, 1'b0);
        step("hyst_rel",     1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 14, 5, 2'b00, 2'b00, 2'b11, 1'b0);
        step("restall",      1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 14, 5, 2'b00, 2'b00, 2'b10, 1'b0);
        step("mask_rel",     1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 14, 5, 2'b00, 2'b00, 2'b00, 1'b0);
        step("en_none",      1'b1, 1'b0, 2'b00, 2'b00, 1'b0);

        // Empty path
        drive(1'b1, 3, 0, 2'b00, 2'b00, 2'b11, 1'b0);
        step("ae_low",       1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 3, 1, 2'b00, 2'b00, 2'b11, 1'b0);
        step("ae_ok",        1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 3, 0, 2'b00, 2'b00, 2'b01, 1'b0);
        step("ae_mask",      1'b1, 1'b1, 2'b00, 2'b00, 1'b0);

        // Overflow
        drive(1'b1, 16, 5, 2'b01, 2'b00, 2'b11, 1'b0);
        step("ovf_set",      1'b0, 1'b1, 2'b01, 2'b00, 1'b1);
        drive(1'b1, 16, 5, 2'b00, 2'b00, 2'b11, 1'b1);
        step("ovf_clr",      1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 16, 5, 2'b01, 2'b01, 2'b11, 1'b0);
        step("pushpop_full", 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 16, 5, 2'b01, 2'b00, 2'b11, 1'b1);
        step("set_wins",     1'b0, 1'b1, 2'b01, 2'b00, 1'b1);
        drive(1'b1, 16, 5, 2'b00, 2'b00, 2'b11, 1'b0);
        step("ovf_sticky",   1'b0, 1'b1, 2'b01, 2'b00, 1'b1);

        // Underflow
        drive(1'b1, 5, 0, 2'b00, 2'b00, 2'b11, 1'b1);
        step("clr_rel",      1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 5, 0, 2'b10, 2'b10, 2'b11, 1'b0);
        step("udf_set",      1'b1, 1'b0, 2'b00, 2'b10, 1'b1);
        drive(1'b1, 5, 0, 2'b00, 2'b00, 2'b11, 1'b1);
        step("udf_clr",      1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 5, 0, 2'b10, 2'b10, 2'b01, 1'b0);
        step("udf_masked",   1'b1, 1'b1, 2'b00, 2'b00, 1'b0);

        // Out-of-contract level and reset mid-operation
        drive(1'b1, 20, 3, 2'b01, 2'b00, 2'b11, 1'b0);
        step("over_depth",   1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 16, 3, 2'b01, 2'b00, 2'b11, 1'b0);
        step("pre_reset",    1'b0, 1'b1, 2'b01, 2'b00, 1'b1);
        drive(1'b0, 16, 3, 2'b01, 2'b00, 2'b11, 1'b0);
        step("mid_reset",    1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 0, 0, 2'b00, 2'b00, 2'b11, 1'b0);
        step("post_reset",   1'b1, 1'b0, 2'b00, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
